// File: rtl/div_seq_ctrl_pkg.sv
// Shared M-extension constants for the sequential divider.
// Holds FSM state encoding, divide op codes and op helpers.
package div_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_DIV        = 3'b100;
  localparam logic [2:0] F3_DIVU       = 3'b101;
  localparam logic [2:0] F3_REM        = 3'b110;
  localparam logic [2:0] F3_REMU       = 3'b111;

  function automatic logic op_signed(op_e op);
    return !op[0];
  endfunction

  function automatic logic op_rem(op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between a requester and the divider.
// Master drives the request and flush, slave returns status and result.
interface div_seq_ctrl_if #(
  parameter int N = 32
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         flush;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  modport master (
    output start, op, dividend, divisor, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output busy, done, result
  );
endinterface

// File: rtl/div_seq_ctrl_divu_iter.sv
// One restoring-division step on magnitudes, MSB-first.
// The extra difference bit acts as the borrow that decides restore.
module divu_iter #(
  parameter int N = 32
) (
  input  logic [N:0]   rem_i,
  input  logic [N-1:0] quo_i,
  input  logic [N-1:0] dsr_i,
  output logic [N:0]   rem_o,
  output logic [N-1:0] quo_o
);

  logic [N:0]   sh;
  logic [N+1:0] diff;
  logic         neg;

  assign sh    = {rem_i[N-1:0], quo_i[N-1]};
  assign diff  = {1'b0, sh} - {2'b00, dsr_i};
  assign neg   = diff[N+1];
  assign rem_o = neg ? sh : diff[N:0];
  assign quo_o = {quo_i[N-2:0], ~neg};

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential RV32M-style divider: IDLE -> CALC (N steps) -> FIX.
// Signs are stripped at accept and reapplied in FIX.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input logic           clk,
  input logic           rst,
  div_seq_ctrl_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  op_e           op_q;
  logic [N:0]    rem_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  dsr_q;
  logic          qneg_q;
  logic          rneg_q;
  logic [N-1:0]  result_q;
  logic          done_q;
  logic          busy_q;

  logic [N:0]    rem_d;
  logic [N-1:0]  quo_d;

  op_e           op_in;
  logic          sgn_in;
  logic          a_neg;
  logic          b_neg;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic          div0;
  logic          ovf;
  logic [N-1:0]  q_fin;
  logic [N-1:0]  r_fin;
  logic [N-1:0]  res_fin;

  assign op_in  = op_e'(bus.op);
  assign sgn_in = op_signed(op_in);
  assign a_neg  = sgn_in & bus.dividend[N-1];
  assign b_neg  = sgn_in & bus.divisor[N-1];
  assign a_mag  = a_neg ? ('0 - bus.dividend) : bus.dividend;
  assign b_mag  = b_neg ? ('0 - bus.divisor) : bus.divisor;
  assign div0   = (bus.divisor == '0);
  assign ovf    = sgn_in & (bus.dividend == MIN_NEG)
                & (&bus.divisor);

  assign q_fin   = qneg_q ? ('0 - quo_q) : quo_q;
  assign r_fin   = rneg_q ? ('0 - rem_q[N-1:0]) : rem_q[N-1:0];
  assign res_fin = op_rem(op_q) ? r_fin : q_fin;

  divu_iter #(.N(N)) u_iter (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dsr_i (dsr_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_DIV;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (bus.flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_q   <= op_in;
            dsr_q  <= b_mag;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            // Special cases preload final quo/rem so FIX is shared.
            if (div0) begin
              quo_q   <= '1;
              rem_q   <= {1'b0, bus.dividend};
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
              state_q <= ST_FIX;
            end else if (ovf) begin
              quo_q   <= MIN_NEG;
              rem_q   <= '0;
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
              state_q <= ST_FIX;
            end else begin
              quo_q   <= a_mag;
              rem_q   <= '0;
              qneg_q  <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_q <= res_fin;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench: driver queues expected result and done edge,
// monitor pops on every done and checks value and latency.
module tb_div_seq_ctrl;

  typedef struct {
    string       nm;
    logic [31:0] res;
    int          at;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   nvec;
  int   nerr;
  logic [31:0] last_res;
  exp_t sbq[$];

  div_seq_ctrl_if #(.N(32)) bus ();

  div_seq_ctrl #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_done: got done at edge %0d expected none",
                 cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.nm, "_res"}, bus.result, e.res);
        chk({e.nm, "_lat"}, 32'(cyc), 32'(e.at));
        last_res = e.res;
      end
    end
  end

  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                       bit push, logic [31:0] exp, int lat, string nm);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) sbq.push_back('{nm, exp, cyc + 1 + lat});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(string nm);
    int n = 0;
    while (sbq.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s_timeout: got %0d pending expected 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic run(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                     logic [31:0] exp, int lat, string nm);
    issue(op, a, b, 1'b1, exp, lat, nm);
    drain(nm);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    cyc = 0;
    last_res = '0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op = 2'b00;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst = 1'b0;

    run(2'b01, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    run(2'b11, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
    run(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
    run(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
    run(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
    run(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");
    run(2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33, "div_m100_m7");
    run(2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, "div_min_2");
    run(2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, "remu_max_16");
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu_min_max");
    run(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_5_0");
    run(2'b10, 32'd5, 32'd0, 32'd5, 1, "rem_5_0");
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

    // Flush mid-CALC: first request must never complete.
    issue(2'b01, 32'd1000, 32'd3, 1'b0, 32'd0, 0, "flushed");
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_hold", bus.result, last_res);

    // Second request with stray starts while busy.
    issue(2'b01, 32'd9, 32'd3, 1'b1, 32'd3, 33, "divu_9_3");
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b11;
    bus.dividend = 32'd100;
    bus.divisor = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain("divu_9_3");
    repeat (5) @(negedge clk);

    // Flush and start together in IDLE: request dropped.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op = 2'b01;
    bus.dividend = 32'd50;
    bus.divisor = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_busy", {31'd0, bus.busy}, 32'd0);
    repeat (5) @(negedge clk);

    // Reset mid-CALC.
    issue(2'b01, 32'd100, 32'd7, 1'b0, 32'd0, 0, "reset_victim");
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    rst = 1'b0;
    repeat (45) @(negedge clk);

    run(2'b01, 32'd100, 32'd7, 32'd14, 33, "divu_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001: Parameter N, default 32, operand and result width in bits.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  synchronous, active-high reset.
REQ-004: start  input  1  request a divide; sampled only in IDLE.
REQ-005: op  input  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-006: dividend  input  N  first operand; sampled with start.
REQ-007: divisor  input  N  second operand; sampled with start.
REQ-008: flush  input  1  abort any operation in flight.
REQ-009: busy  output  1  high whenever state is not IDLE.
REQ-010: done  output  1  one-cycle pulse; result valid in the same cycle.
REQ-011: result  output  N  quotient or remainder selected by op.

Function
REQ-012: The block SHALL implement the states IDLE, CALC, FIX.
REQ-013: In IDLE with start=1 and flush=0, the block SHALL latch op, operand magnitudes (two's-complement absolute value for DIV/REM, raw for DIVU/REMU) and result signs, then enter CALC with iteration counter 0.
REQ-014: In CALC, the block SHALL perform one restoring-division iteration per cycle: MSB-first, remainder N+1 bits wide, quotient shifted left one bit per cycle.
REQ-015: The counter SHALL increment each CALC cycle; at count N-1 the block SHALL enter FIX.
REQ-016: In FIX, the block SHALL register result and assert done for exactly that cycle, then return to IDLE.
REQ-017: For a start sampled at edge E0, done SHALL be high in the cycle following edge E0+N+1 (cycle after edge 33 for N=32).
REQ-018: Signed quotient sign SHALL be dividend_sign XOR divisor_sign; signed remainder sign SHALL equal the dividend sign; negation is two's complement modulo 2^N.
REQ-019: Divisor zero SHALL bypass CALC (IDLE->FIX, done after edge E0+1): quotient = all ones, remainder = dividend.
REQ-020: Signed overflow (dividend = 2^(N-1), divisor = all ones, op DIV/REM) SHALL bypass CALC: quotient = 2^(N-1), remainder = 0.
REQ-021: start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-022: flush=1 SHALL force IDLE on the next edge from any state; no done is produced, and result holds its previous value.
REQ-023: If flush and start are high together in IDLE, flush SHALL win and the request SHALL be dropped.
REQ-024: result SHALL hold its last value until the next FIX cycle.
REQ-025: The back-to-back rule is fixed: start may be accepted in the cycle after done (IDLE), and not in the FIX cycle itself.

Reset
REQ-026: When rst=1 at a rising edge, the block SHALL enter IDLE and clear the counter, busy, done, result and all operand/remainder registers.
REQ-027: Reset SHALL take precedence over flush and start.
REQ-028: Reset mid-operation SHALL produce no done pulse.

Structure
REQ-029: State encoding (IDLE/CALC/FIX) and op codes SHALL live in a shared package with the other M-extension constants.
REQ-030: The per-cycle step SHALL be one instance of the existing divu_iter sub-module operating on registered rem/quo, with no other sub-modules.
REQ-031: The counter width SHALL be $clog2(N).

Verification
REQ-032: DIVU 100/7 -> done after edge E0+33 (cycle-counted), result 14; REMU same operands -> 2.
REQ-033: DIV -7/2 -> result 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> -3.
REQ-034: DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done after edge E0+1.
REQ-035: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; both with done after edge E0+1.
REQ-036: Flush at CALC cycle 10, then a new DIVU 9/3 -> no done for the first request; second returns 3 after 33 edges; start pulses during busy are ignored.
REQ-037: rst asserted mid-CALC -> next cycle busy=0, done=0, result=0, and no spurious done afterward.
